// File: rtl/bip_fetch_unit.sv
// BIP instruction-fetch and sequencing stage: PC, program-memory read, IR and halt flags.
// Optional active-cycle counter enabled by defining BIP_CYCLE_COUNT_EN.
module bip_fetch_unit #(
    parameter int PC_WIDTH     = 11,
    parameter int OPCODE_WIDTH = 5,
    parameter int INSTR_WIDTH  = 16,
    parameter int MAX_OPCODE   = 7
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    output logic [PC_WIDTH-1:0]             PM_ADDR,
    output logic                            PM_RD_EN,
    input  logic [INSTR_WIDTH-1:0]          PM_DATA,
    output logic [OPCODE_WIDTH-1:0]         OPCODE,
    output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] OPERAND,
    output logic                            INSTR_VALID,
    input  logic                            WR_PC,
    output logic                            HALTED,
    output logic                            ILLEGAL_OP,
    output logic [31:0]                     CYCLE_COUNT
);

    localparam logic [OPCODE_WIDTH-1:0] MAX_OP_L = MAX_OPCODE[OPCODE_WIDTH-1:0];

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t                   state_r;
    logic [PC_WIDTH-1:0]      pc_r;
    logic [INSTR_WIDTH-1:0]   ir_r;
    logic                     pm_rd_en_r;
    logic                     instr_valid_r;
    logic                     halted_r;
    logic                     illegal_op_r;

    function automatic logic is_illegal(input logic [OPCODE_WIDTH-1:0] op);
        return (op > MAX_OP_L);
    endfunction

    // Sequencer: strobes are set on the edge entering their state so they are registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= ST_IDLE;
            pc_r          <= {PC_WIDTH{1'b0}};
            ir_r          <= {INSTR_WIDTH{1'b0}};
            pm_rd_en_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
            illegal_op_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r    <= ST_FETCH;
                        pm_rd_en_r <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        pm_rd_en_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_r    <= ST_LOAD;
                    pm_rd_en_r <= 1'b0;
                end
                ST_LOAD: begin
                    ir_r          <= PM_DATA;
                    state_r       <= ST_EXEC;
                    instr_valid_r <= 1'b1;
                end
                ST_EXEC: begin
                    instr_valid_r <= 1'b0;
                    if (WR_PC) begin
                        pc_r       <= pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                        state_r    <= ST_FETCH;
                        pm_rd_en_r <= 1'b1;
                    end else begin
                        halted_r     <= 1'b1;
                        illegal_op_r <= is_illegal(ir_r[INSTR_WIDTH-1 -: OPCODE_WIDTH]);
                        state_r      <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_r       <= ST_HALT;
                    pm_rd_en_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    pm_rd_en_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cycle_count_r;
    logic        active_s;

    assign active_s = (state_r == ST_FETCH) || (state_r == ST_LOAD) || (state_r == ST_EXEC);

    // Saturating count of cycles spent executing instructions.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_count_r <= 32'd0;
        end else if (active_s && (cycle_count_r != 32'hFFFF_FFFF)) begin
            cycle_count_r <= cycle_count_r + 32'd1;
        end else begin
            cycle_count_r <= cycle_count_r;
        end
    end

    assign CYCLE_COUNT = cycle_count_r;
`else
    assign CYCLE_COUNT = 32'd0;
`endif

    assign PM_ADDR     = pc_r;
    assign PM_RD_EN    = pm_rd_en_r;
    assign OPCODE      = ir_r[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign OPERAND     = ir_r[INSTR_WIDTH-OPCODE_WIDTH-1:0];
    assign INSTR_VALID = instr_valid_r;
    assign HALTED      = halted_r;
    assign ILLEGAL_OP  = illegal_op_r;

endmodule

// File: tb/tb_bip_fetch_unit.sv
// Self-checking bench for bip_fetch_unit: instruction-level reference model, directed and random programs.
module tb_bip_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] pm_addr;
    logic        pm_rd_en;
    logic [15:0] pm_data = 16'd0;
    logic [4:0]  opcode;
    logic [10:0] operand;
    logic        instr_valid;
    logic        wr_pc;
    logic        halted;
    logic        illegal_op;
    logic [31:0] cycle_count;

    logic        noise = 1'b0;
    logic [15:0] mem [0:2047];

    int n_total = 0;
    int n_pass  = 0;

    // reference model state: instruction phase 0=fetch 1=load 2=exec while running
    bit          m_run, m_halt, m_ill;
    int          m_ph;
    int          m_pc;
    logic [15:0] m_ir;
    longint      m_cnt;

    bip_fetch_unit dut (
        .CLK(clk), .RST(rst), .START(start), .PM_ADDR(pm_addr), .PM_RD_EN(pm_rd_en),
        .PM_DATA(pm_data), .OPCODE(opcode), .OPERAND(operand), .INSTR_VALID(instr_valid),
        .WR_PC(wr_pc), .HALTED(halted), .ILLEGAL_OP(illegal_op), .CYCLE_COUNT(cycle_count)
    );

    always #5 clk = ~clk;

    // synchronous program memory
    always @(posedge clk) if (pm_rd_en) pm_data <= mem[pm_addr];

    // decoder stand-in: HALT is opcode 0, undefined opcodes also stop; noise outside EXEC
    always_comb begin
        if (instr_valid) wr_pc = (opcode != 5'd0) && (opcode <= 5'd7);
        else             wr_pc = noise;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare();
        longint exp_cnt;
`ifdef BIP_CYCLE_COUNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        check("pm_addr", pm_addr, m_pc);
        check("ctrl", {pm_rd_en, instr_valid, halted, illegal_op},
              {m_run && m_ph == 0, m_run && m_ph == 2, m_halt, m_ill});
        check("ir", {opcode, operand}, m_ir);
        check("cycle_count", cycle_count, exp_cnt);
    endtask

    task automatic model_step(input bit r, input bit s, input bit w);
        if (r) begin
            m_run = 0; m_halt = 0; m_ill = 0; m_ph = 0; m_pc = 0; m_ir = 16'd0; m_cnt = 0;
        end else if (m_run) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_ph == 0) m_ph = 1;
            else if (m_ph == 1) begin
                m_ir = mem[m_pc];
                m_ph = 2;
            end else if (w) begin
                m_pc = (m_pc + 1) % 2048;
                m_ph = 0;
            end else begin
                m_run = 0; m_halt = 1;
                m_ill = (m_ir[15:11] > 5'd7);
            end
        end else if (!m_halt && s) begin
            m_run = 1; m_ph = 0;
        end
    endtask

    // one clock: check outputs, drive inputs, advance model at the edge
    task automatic cycle(input bit r, input bit s);
        bit w;
        @(negedge clk);
        compare();
        rst = r; start = s; noise = 1'($urandom_range(0, 1));
        #2;
        w = wr_pc;
        @(posedge clk);
        model_step(r, s, w);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic clear_mem(input logic [15:0] v);
        for (int i = 0; i < 2048; i++) mem[i] = v;
    endtask

    initial begin
        logic [4:0] op;
        m_run = 0; m_halt = 0; m_ill = 0; m_ph = 0; m_pc = 0; m_ir = 16'd0; m_cnt = 0;

        // single ADDI then HALT: strobe timing and PC advance
        clear_mem(16'h0000);
        mem[0] = {5'b00101, 11'h055};
        @(posedge clk);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        #1 check("lit_rd_en_after_start", pm_rd_en, 1);
        run(2);
        #1 check("lit_valid_exec", {instr_valid, opcode}, {1'b1, 5'b00101});
        run(1);
        #1 check("lit_pc_after_exec", pm_addr, 1);
        run(3);

        // LDI, ADD, STO, HALT
        clear_mem(16'h0000);
        mem[0] = {5'd3, 11'h010}; mem[1] = {5'd4, 11'h020};
        mem[2] = {5'd1, 11'h030}; mem[3] = {5'd0, 11'h000};
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        run(12);
`ifdef BIP_CYCLE_COUNT_EN
        #1 check("lit_prog_done", {halted, illegal_op, pm_addr, cycle_count}, {1'b1, 1'b0, 11'd3, 32'd12});
`else
        #1 check("lit_prog_done", {halted, illegal_op, pm_addr, cycle_count}, {1'b1, 1'b0, 11'd3, 32'd0});
`endif

        // undefined opcode, then START while halted is ignored
        mem[0] = {5'b01010, 11'h7FF};
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        run(3);
        #1 check("lit_illegal", {halted, illegal_op, pm_addr}, {1'b1, 1'b1, 11'd0});
        cycle(1'b0, 1'b1);
        run(3);
        #1 check("lit_halt_sticky", {halted, pm_rd_en, instr_valid, pm_addr}, {1'b1, 1'b0, 1'b0, 11'd0});

        // reset during LOAD after two instructions
        clear_mem({5'b00101, 11'h001});
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        run(7);
        cycle(1'b1, 1'b0);
        #1 check("lit_rst_in_load", {instr_valid, pm_rd_en, halted, pm_addr}, {1'b0, 1'b0, 1'b0, 11'd0});

        // START with RST in the same cycle
        cycle(1'b1, 1'b1);
        run(3);
        #1 check("lit_start_with_rst", {pm_rd_en, instr_valid}, {1'b0, 1'b0});

        // PC wrap: ADDI everywhere
        cycle(1'b0, 1'b1);
        run(2048 * 3);
        #1 check("lit_pc_wrapped", {pm_addr, pm_rd_en}, {11'd0, 1'b1});
        run(3);
        #1 check("lit_fetch_after_wrap", pm_addr, 1);

        // random programs with random START and occasional RST
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 2048; i++) begin
                op = 5'($urandom_range(1, 7));
                if ($urandom_range(0, 39) == 0) op = 5'd0;
                else if ($urandom_range(0, 59) == 0) op = 5'($urandom_range(8, 31));
                mem[i] = {op, 11'($urandom)};
            end
            cycle(1'b1, 1'($urandom_range(0, 1)));
            for (int i = 0; i < 500; i++)
                cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0));
        end
        cycle(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bip_fetch_unit.md
Name: bip_fetch_unit

Overview:
Instruction-fetch and sequencing stage of the BIP processor. It sits directly upstream of the instruction decoder.
- Holds the PC and reads the synchronous program memory.
- Latches the instruction register (IR) and presents OPCODE/OPERAND to the decoder.
- Consumes the decoder's WR_PC: WR_PC=1 advances the PC; WR_PC=0 (HALT or undefined opcode) stops the machine.

Parameters:
PC_WIDTH, 11, program-memory address width and PC width.
OPCODE_WIDTH, 5, opcode field width; IR bits [INSTR_WIDTH-1 -: OPCODE_WIDTH].
INSTR_WIDTH, 16, instruction word width; OPERAND is IR[INSTR_WIDTH-OPCODE_WIDTH-1:0].
MAX_OPCODE, 7, highest defined opcode; anything above it is flagged illegal at halt.

Ports:
CLK  in  1  single system clock, rising edge.
RST  in  1  synchronous, active-high reset.
START  in  1  one-cycle pulse; leaves IDLE and begins execution at PC.
PM_ADDR  out  PC_WIDTH  program-memory address (always equals PC).
PM_RD_EN  out  1  program-memory read enable; data returns the next cycle.
PM_DATA  in  INSTR_WIDTH  program-memory read data.
OPCODE  out  OPCODE_WIDTH  IR opcode field, to decoder.
OPERAND  out  INSTR_WIDTH-OPCODE_WIDTH  IR operand field, to datapath.
INSTR_VALID  out  1  high in EXEC only; decoder outputs are meaningful.
WR_PC  in  1  from decoder: 1 = advance PC, 0 = halt.
HALTED  out  1  sticky halt indicator.
ILLEGAL_OP  out  1  sticky; set when the halt was caused by opcode > MAX_OPCODE.
CYCLE_COUNT  out  32  active-cycle counter (see Optional Feature).

Behaviour:
- Reset (RST=1 at an edge) wins over all other inputs:
  - state=IDLE, PC=0, IR=0.
  - OPCODE=0, OPERAND=0, PM_RD_EN=0, INSTR_VALID=0, HALTED=0, ILLEGAL_OP=0, CYCLE_COUNT=0.
- Reset mid-instruction aborts it: no PC update and no flag update at that edge.
- States: IDLE, FETCH, LOAD, EXEC, HALT. CPI = 3 cycles.
- IDLE:
  - PM_RD_EN=0.
  - START=1 -> FETCH; otherwise stay.
- FETCH:
  - PM_RD_EN=1, PM_ADDR=PC.
  - Unconditionally -> LOAD.
- LOAD:
  - PM_RD_EN=0.
  - IR <= PM_DATA at the end of this cycle; -> EXEC.
- EXEC:
  - INSTR_VALID=1; OPCODE/OPERAND driven from IR and stable for the whole cycle.
  - WR_PC is sampled at the closing edge.
  - WR_PC=1: PC <= PC+1 modulo 2^PC_WIDTH (all-ones wraps to 0); -> FETCH.
  - WR_PC=0: PC unchanged; HALTED<=1; ILLEGAL_OP <= (OPCODE > MAX_OPCODE); -> HALT.
- HALT:
  - Terminal until RST. PM_RD_EN=0, INSTR_VALID=0.
  - IR, PC, OPCODE and OPERAND hold their last values.
- START outside IDLE is ignored, including in HALT.
- START and RST in the same cycle: reset wins, state=IDLE; START must be re-pulsed.
- WR_PC outside EXEC is ignored.
- OPCODE/OPERAND change only at the LOAD->EXEC edge; they never glitch between instructions.
- PM_ADDR is a registered copy of PC and is valid in every state.

Optional Feature:
Macro: BIP_CYCLE_COUNT_EN.
- Defined:
  - CYCLE_COUNT increments by 1 every cycle the state is FETCH, LOAD or EXEC.
  - Holds in IDLE and HALT; saturates at 32'hFFFF_FFFF; cleared only by RST.
- Undefined:
  - No counter logic is instantiated; the CYCLE_COUNT port remains, tied to 0.

Test Plan:
- Reset then START; memory[0]=ADDI (5'b00101) -> PM_RD_EN high in cycle 1 after START; INSTR_VALID high in cycle 3 with OPCODE=5'b00101; PC=1 after EXEC.
- Program LDI, ADD, STO, HALT at addresses 0-3 with decoder in loop -> HALTED=1 after 12 active cycles; PC=3; ILLEGAL_OP=0; CYCLE_COUNT=12 with BIP_CYCLE_COUNT_EN, 0 without.
- Opcode 5'b01010 at address 0 -> halts after the first EXEC; HALTED=1, ILLEGAL_OP=1, PC=0.
- PC preset near top (NOPs of ADDI through address 2047, PC_WIDTH=11) -> PC wraps 2047->0 and fetch continues from address 0.
- RST asserted during LOAD -> next cycle state=IDLE, PC=0, INSTR_VALID=0; START pulsed while HALTED -> no change.
- START and RST in the same cycle -> stays IDLE, PM_RD_EN stays 0 until a later START.
